// File: rtl/multicyc_main_fsm_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM:
// state codes, ISA opcodes/functs, datapath select encodings and the control bundle.
package multicyc_main_fsm_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXEC_R  = 4'd6,
      RWB     = 4'd7,
      EXEC_I  = 4'd8,
      IWB     = 4'd9,
      BRANCH  = 4'd10,
      JUMP    = 4'd11,
      JREG    = 4'd12,
      ILLEGAL = 4'd13
   } state_t;

   localparam logic [5:0] OP_RSTYLE = 6'b000000;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_SLTIU  = 6'b001011;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [5:0] FN_JR     = 6'b001000;
   localparam logic [5:0] FN_JALR   = 6'b001001;

   localparam logic [1:0] PCSRC_ALU     = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
   localparam logic [1:0] PCSRC_JUMP    = 2'b10;
   localparam logic [1:0] PCSRC_RS      = 2'b11;

   localparam logic       ALUSRCA_PC    = 1'b0;
   localparam logic       ALUSRCA_RS    = 1'b1;

   localparam logic [1:0] ALUSRCB_RT    = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_BRIMM = 2'b11;

   localparam logic [1:0] ALUOP_ADD     = 2'b00;
   localparam logic [1:0] ALUOP_SUB     = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
   localparam logic [1:0] ALUOP_OPCODE  = 2'b11;

   localparam logic [1:0] REGDST_RT     = 2'b00;
   localparam logic [1:0] REGDST_RD     = 2'b01;
   localparam logic [1:0] REGDST_RA     = 2'b10;

   localparam logic [1:0] WBSRC_ALUOUT  = 2'b00;
   localparam logic [1:0] WBSRC_MDR     = 2'b01;
   localparam logic [1:0] WBSRC_PC      = 2'b10;

   typedef struct packed {
      logic       instRead;
      logic       irWrite;
      logic       pcWrite;
      logic       branch;
      logic       branchEq;
      logic [1:0] pcSrc;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic       memRead;
      logic       memWrite;
      logic       regWrite;
      logic [1:0] regDst;
      logic [1:0] memtoReg;
      logic       retire;
   } ctrl_t;

   // Instruction class dispatch taken out of DECODE.
   function automatic state_t decodeDispatch(input logic [5:0] opCode, input logic [5:0] funct);
      state_t nextState;
      case (opCode)
         OP_LW, OP_SW:
            nextState = MEMADR;
         OP_RSTYLE:
            nextState = (funct == FN_JR || funct == FN_JALR) ? JREG : EXEC_R;
         OP_LUI, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU:
            nextState = EXEC_I;
         OP_BEQ, OP_BNE:
            nextState = BRANCH;
         OP_J, OP_JAL:
            nextState = JUMP;
         default:
            nextState = ILLEGAL;
      endcase
      return nextState;
   endfunction

endpackage

// File: rtl/multicyc_main_fsm_if.sv
// Control/handshake bundle between the main FSM (master) and the multicycle datapath and memories (slave).
interface multicyc_main_fsm_if #(
   parameter int COUNT_W = 32
);
   logic [5:0]         iOpCode;
   logic [5:0]         iFunct;
   logic               iInstReady;
   logic               iDataReady;
   logic               oInstRead;
   logic               oIRWrite;
   logic               oPCWrite;
   logic               oBranch;
   logic               oBranchEq;
   logic [1:0]         oPCSrc;
   logic               oAluSrcA;
   logic [1:0]         oAluSrcB;
   logic [1:0]         oAluOp;
   logic               oMemRead;
   logic               oMemWrite;
   logic               oRegWrite;
   logic [1:0]         oRegDst;
   logic [1:0]         oMemtoReg;
   logic               oRetire;
   logic [COUNT_W-1:0] oInstCount;
   logic               oIllegal;
   logic [3:0]         oState;

   modport master (
      input  iOpCode, iFunct, iInstReady, iDataReady,
      output oInstRead, oIRWrite, oPCWrite, oBranch, oBranchEq, oPCSrc,
             oAluSrcA, oAluSrcB, oAluOp, oMemRead, oMemWrite, oRegWrite,
             oRegDst, oMemtoReg, oRetire, oInstCount, oIllegal, oState
   );

   modport slave (
      output iOpCode, iFunct, iInstReady, iDataReady,
      input  oInstRead, oIRWrite, oPCWrite, oBranch, oBranchEq, oPCSrc,
             oAluSrcA, oAluSrcB, oAluOp, oMemRead, oMemWrite, oRegWrite,
             oRegDst, oMemtoReg, oRetire, oInstCount, oIllegal, oState
   );
endinterface

// File: rtl/multicyc_fsm_outdec.sv
// Control output decoder: Moore decode of state, plus the ready-qualified fetch load and store retire.
module multicyc_fsm_outdec
   import multicyc_main_fsm_pkg::*;
(
   input  state_t     state_i,
   input  logic [5:0] opCode_i,
   input  logic [5:0] funct_i,
   input  logic       instReady_i,
   input  logic       dataReady_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         FETCH: begin
            ctrl_o.instRead = 1'b1;
            ctrl_o.aluSrcA  = ALUSRCA_PC;
            ctrl_o.aluSrcB  = ALUSRCB_FOUR;
            ctrl_o.aluOp    = ALUOP_ADD;
            ctrl_o.pcSrc    = PCSRC_ALU;
            ctrl_o.irWrite  = instReady_i;
            ctrl_o.pcWrite  = instReady_i;
         end
         DECODE: begin
            ctrl_o.aluSrcA = ALUSRCA_PC;
            ctrl_o.aluSrcB = ALUSRCB_BRIMM;
            ctrl_o.aluOp   = ALUOP_ADD;
         end
         MEMADR: begin
            ctrl_o.aluSrcA = ALUSRCA_RS;
            ctrl_o.aluSrcB = ALUSRCB_IMM;
            ctrl_o.aluOp   = ALUOP_ADD;
         end
         MEMRD: ctrl_o.memRead = 1'b1;
         MEMWB: begin
            ctrl_o.regWrite = 1'b1;
            ctrl_o.regDst   = REGDST_RT;
            ctrl_o.memtoReg = WBSRC_MDR;
            ctrl_o.retire   = 1'b1;
         end
         MEMWR: begin
            ctrl_o.memWrite = 1'b1;
            ctrl_o.retire   = dataReady_i;
         end
         EXEC_R: begin
            ctrl_o.aluSrcA = ALUSRCA_RS;
            ctrl_o.aluSrcB = ALUSRCB_RT;
            ctrl_o.aluOp   = ALUOP_FUNCT;
         end
         RWB: begin
            ctrl_o.regWrite = 1'b1;
            ctrl_o.regDst   = REGDST_RD;
            ctrl_o.memtoReg = WBSRC_ALUOUT;
            ctrl_o.retire   = 1'b1;
         end
         EXEC_I: begin
            ctrl_o.aluSrcA = ALUSRCA_RS;
            ctrl_o.aluSrcB = ALUSRCB_IMM;
            ctrl_o.aluOp   = ALUOP_OPCODE;
         end
         IWB: begin
            ctrl_o.regWrite = 1'b1;
            ctrl_o.regDst   = REGDST_RT;
            ctrl_o.memtoReg = WBSRC_ALUOUT;
            ctrl_o.retire   = 1'b1;
         end
         BRANCH: begin
            ctrl_o.aluSrcA  = ALUSRCA_RS;
            ctrl_o.aluSrcB  = ALUSRCB_RT;
            ctrl_o.aluOp    = ALUOP_SUB;
            ctrl_o.branch   = 1'b1;
            ctrl_o.branchEq = (opCode_i == OP_BEQ);
            ctrl_o.pcSrc    = PCSRC_ALUOUT;
            ctrl_o.retire   = 1'b1;
         end
         JUMP: begin
            ctrl_o.pcWrite = 1'b1;
            ctrl_o.pcSrc   = PCSRC_JUMP;
            ctrl_o.retire  = 1'b1;
            if (opCode_i == OP_JAL) begin
               ctrl_o.regWrite = 1'b1;
               ctrl_o.regDst   = REGDST_RA;
               ctrl_o.memtoReg = WBSRC_PC;
            end
         end
         JREG: begin
            ctrl_o.pcWrite = 1'b1;
            ctrl_o.pcSrc   = PCSRC_RS;
            ctrl_o.retire  = 1'b1;
            if (funct_i == FN_JALR) begin
               ctrl_o.regWrite = 1'b1;
               ctrl_o.regDst   = REGDST_RD;
               ctrl_o.memtoReg = WBSRC_PC;
            end
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicyc_main_fsm.sv
// Main control FSM of the multicycle MIPS core: state register, next-state logic,
// retired-instruction counter and sticky illegal flag around the output decoder.
module multicyc_main_fsm
   import multicyc_main_fsm_pkg::*;
#(
   parameter int COUNT_W = 32
) (
   input  logic                 iClk,
   input  logic                 iRst_n,
   multicyc_main_fsm_if.master  bus
);

   state_t             stateQ, stateD;
   logic [COUNT_W-1:0] countQ;
   logic               illegalQ;
   ctrl_t              decCtrl;
   ctrl_t              ctrl;

   multicyc_fsm_outdec u_outdec (
      .state_i     (stateQ),
      .opCode_i    (bus.iOpCode),
      .funct_i     (bus.iFunct),
      .instReady_i (bus.iInstReady),
      .dataReady_i (bus.iDataReady),
      .ctrl_o      (decCtrl)
   );

   // Reset forces every strobe low at once, so a request in flight is dropped without waiting for a clock.
   always_comb begin
      ctrl = decCtrl;
      if (!iRst_n) ctrl = '0;
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         FETCH:   if (bus.iInstReady) stateD = DECODE;
         DECODE:  stateD = decodeDispatch(bus.iOpCode, bus.iFunct);
         MEMADR:  stateD = (bus.iOpCode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   if (bus.iDataReady) stateD = MEMWB;
         MEMWR:   if (bus.iDataReady) stateD = FETCH;
         EXEC_R:  stateD = RWB;
         EXEC_I:  stateD = IWB;
         MEMWB, RWB, IWB, BRANCH, JUMP, JREG:
                  stateD = FETCH;
         ILLEGAL: stateD = ILLEGAL;
         default: stateD = ILLEGAL;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         stateQ   <= FETCH;
         countQ   <= '0;
         illegalQ <= 1'b0;
      end else begin
         stateQ <= stateD;
         if (ctrl.retire) countQ <= countQ + COUNT_W'(1);
         if (stateD == ILLEGAL) illegalQ <= 1'b1;
      end
   end

   assign bus.oInstRead  = ctrl.instRead;
   assign bus.oIRWrite   = ctrl.irWrite;
   assign bus.oPCWrite   = ctrl.pcWrite;
   assign bus.oBranch    = ctrl.branch;
   assign bus.oBranchEq  = ctrl.branchEq;
   assign bus.oPCSrc     = ctrl.pcSrc;
   assign bus.oAluSrcA   = ctrl.aluSrcA;
   assign bus.oAluSrcB   = ctrl.aluSrcB;
   assign bus.oAluOp     = ctrl.aluOp;
   assign bus.oMemRead   = ctrl.memRead;
   assign bus.oMemWrite  = ctrl.memWrite;
   assign bus.oRegWrite  = ctrl.regWrite;
   assign bus.oRegDst    = ctrl.regDst;
   assign bus.oMemtoReg  = ctrl.memtoReg;
   assign bus.oRetire    = ctrl.retire;
   assign bus.oInstCount = countQ;
   assign bus.oIllegal   = illegalQ;
   assign bus.oState     = stateQ;

endmodule

// File: tb/tb_multicyc_main_fsm.sv
// Scoreboard bench for multicyc_main_fsm: expected per-cycle state, controls and count are queued
// as stimulus is driven and compared against what the FSM produced.
module tb_multicyc_main_fsm;

   logic iClk   = 1'b0;
   logic iRst_n = 1'b0;

   always #5 iClk = ~iClk;

   multicyc_main_fsm_if #(.COUNT_W(4)) bus ();

   multicyc_main_fsm #(.COUNT_W(4)) dut (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .bus    (bus)
   );

   typedef struct packed {
      logic       instRead;
      logic       irWrite;
      logic       pcWrite;
      logic       branch;
      logic       branchEq;
      logic [1:0] pcSrc;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic       memRead;
      logic       memWrite;
      logic       regWrite;
      logic [1:0] regDst;
      logic [1:0] memtoReg;
      logic       retire;
      logic       illegal;
   } tbCtrl_t;

   typedef struct packed {
      logic [3:0] st;
      tbCtrl_t    ctrl;
      logic [3:0] count;
   } entry_t;

   entry_t     expQ[$];
   entry_t     obsQ[$];
   int         checkCnt = 0;
   int         passCnt  = 0;
   logic [3:0] expCount = 4'd0;
   entry_t     obsNow;

   // Expected outputs for a state, written straight from the control table of the core.
   function automatic tbCtrl_t expCtrl(input logic [3:0] st, input logic [5:0] op,
                                       input logic [5:0] fn, input logic rdy);
      tbCtrl_t c;
      c = '0;
      case (st)
         4'd0:  begin c.instRead = 1'b1; c.aluSrcB = 2'b01; c.irWrite = rdy; c.pcWrite = rdy; end
         4'd1:  c.aluSrcB = 2'b11;
         4'd2:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
         4'd3:  c.memRead = 1'b1;
         4'd4:  begin c.regWrite = 1'b1; c.memtoReg = 2'b01; c.retire = 1'b1; end
         4'd5:  begin c.memWrite = 1'b1; c.retire = rdy; end
         4'd6:  begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
         4'd7:  begin c.regWrite = 1'b1; c.regDst = 2'b01; c.retire = 1'b1; end
         4'd8:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = 2'b11; end
         4'd9:  begin c.regWrite = 1'b1; c.retire = 1'b1; end
         4'd10: begin
            c.aluSrcA = 1'b1; c.aluOp = 2'b01; c.branch = 1'b1;
            c.branchEq = (op == 6'b000100); c.pcSrc = 2'b01; c.retire = 1'b1;
         end
         4'd11: begin
            c.pcWrite = 1'b1; c.pcSrc = 2'b10; c.retire = 1'b1;
            if (op == 6'b000011) begin c.regWrite = 1'b1; c.regDst = 2'b10; c.memtoReg = 2'b10; end
         end
         4'd12: begin
            c.pcWrite = 1'b1; c.pcSrc = 2'b11; c.retire = 1'b1;
            if (fn == 6'b001001) begin c.regWrite = 1'b1; c.regDst = 2'b01; c.memtoReg = 2'b10; end
         end
         4'd13: c.illegal = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   task automatic sampleNow();
      obsNow.st    = bus.oState;
      obsNow.ctrl  = {bus.oInstRead, bus.oIRWrite, bus.oPCWrite, bus.oBranch, bus.oBranchEq,
                      bus.oPCSrc, bus.oAluSrcA, bus.oAluSrcB, bus.oAluOp, bus.oMemRead,
                      bus.oMemWrite, bus.oRegWrite, bus.oRegDst, bus.oMemtoReg, bus.oRetire,
                      bus.oIllegal};
      obsNow.count = bus.oInstCount;
   endtask

   // Drives one instruction cycle by cycle: seq holds the expected state per cycle (nibble c),
   // rdy the ready level presented on both memory ports in that cycle.
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                input logic [31:0] seq, input logic [7:0] rdy, input int n);
      entry_t e;
      bus.iOpCode = op;
      bus.iFunct  = fn;
      for (int c = 0; c < n; c++) begin
         e.st    = seq[4*c +: 4];
         e.ctrl  = expCtrl(e.st, op, fn, rdy[c]);
         e.count = expCount;
         expQ.push_back(e);
         if (e.ctrl.retire) expCount = expCount + 4'd1;
         bus.iInstReady = rdy[c];
         bus.iDataReady = rdy[c];
         @(negedge iClk);
         sampleNow();
         obsQ.push_back(obsNow);
         @(posedge iClk);
         #1;
      end
   endtask

   task automatic test_reset();
      bus.iOpCode = 6'd0; bus.iFunct = 6'd0; bus.iInstReady = 1'b1; bus.iDataReady = 1'b1;
      iRst_n = 1'b0;
      repeat (2) @(posedge iClk);
      @(negedge iClk);
      sampleNow();
      checkCnt++;
      if (obsNow.st !== 4'd0) $display("[TB] FAIL reset_state: got %0d, want 0", obsNow.st);
      else passCnt++;
      checkCnt++;
      if (obsNow.count !== 4'd0) $display("[TB] FAIL reset_count: got %0d, want 0", obsNow.count);
      else passCnt++;
      checkCnt++;
      if (obsNow.ctrl !== tbCtrl_t'(0)) $display("[TB] FAIL reset_ctrl: got %h, want 0", obsNow.ctrl);
      else passCnt++;
      @(posedge iClk);
      #1 iRst_n = 1'b1;
      expCount = 4'd0;
   endtask

   task automatic test_addu();
      entry_t e, o;
      applyStimulus(6'b000000, 6'b100001, 32'h0000_7610, 8'h0F, 4);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front();
         checkCnt++;
         if (o !== e) $display("[TB] FAIL addu st%0d: got st=%0d ctrl=%h cnt=%0d, want st=%0d ctrl=%h cnt=%0d",
                               e.st, o.st, o.ctrl, o.count, e.st, e.ctrl, e.count);
         else passCnt++;
      end
      checkCnt++;
      if (bus.oInstCount !== 4'd1) $display("[TB] FAIL addu_count: got %0d, want 1", bus.oInstCount);
      else passCnt++;
   endtask

   task automatic test_lw_wait();
      entry_t e, o;
      int memReads = 0, regWrites = 0;
      applyStimulus(6'b100011, 6'd0, 32'h0433_3210, 8'b0110_0111, 7);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front();
         memReads  += int'(o.ctrl.memRead);
         regWrites += int'(o.ctrl.regWrite);
         checkCnt++;
         if (o !== e) $display("[TB] FAIL lw st%0d: got st=%0d ctrl=%h cnt=%0d, want st=%0d ctrl=%h cnt=%0d",
                               e.st, o.st, o.ctrl, o.count, e.st, e.ctrl, e.count);
         else passCnt++;
      end
      checkCnt++;
      if (memReads != 3) $display("[TB] FAIL lw_memread_cycles: got %0d, want 3", memReads);
      else passCnt++;
      checkCnt++;
      if (regWrites != 1) $display("[TB] FAIL lw_regwrite_cycles: got %0d, want 1", regWrites);
      else passCnt++;
   endtask

   task automatic test_branch();
      entry_t e, o;
      applyStimulus(6'b000100, 6'd0, 32'h0000_0A10, 8'h07, 3);
      applyStimulus(6'b000101, 6'd0, 32'h0000_0A10, 8'h07, 3);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front();
         checkCnt++;
         if (o !== e) $display("[TB] FAIL branch st%0d: got st=%0d ctrl=%h cnt=%0d, want st=%0d ctrl=%h cnt=%0d",
                               e.st, o.st, o.ctrl, o.count, e.st, e.ctrl, e.count);
         else passCnt++;
      end
   endtask

   task automatic test_jumps();
      entry_t e, o;
      applyStimulus(6'b000011, 6'd0,      32'h0000_0B10, 8'h07, 3);
      applyStimulus(6'b000000, 6'b001001, 32'h0000_0C10, 8'h07, 3);
      applyStimulus(6'b000000, 6'b001000, 32'h0000_0C10, 8'h07, 3);
      applyStimulus(6'b000010, 6'd0,      32'h0000_0B10, 8'h07, 3);
      applyStimulus(6'b001111, 6'd0,      32'h0000_9810, 8'h0F, 4);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front();
         checkCnt++;
         if (o !== e) $display("[TB] FAIL jump st%0d: got st=%0d ctrl=%h cnt=%0d, want st=%0d ctrl=%h cnt=%0d",
                               e.st, o.st, o.ctrl, o.count, e.st, e.ctrl, e.count);
         else passCnt++;
      end
   endtask

   task automatic test_sw_reset();
      entry_t e, o;
      applyStimulus(6'b101011, 6'd0, 32'h0000_5210, 8'h0F, 4);
      applyStimulus(6'b101011, 6'd0, 32'h0000_0210, 8'h07, 3);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front();
         checkCnt++;
         if (o !== e) $display("[TB] FAIL sw st%0d: got st=%0d ctrl=%h cnt=%0d, want st=%0d ctrl=%h cnt=%0d",
                               e.st, o.st, o.ctrl, o.count, e.st, e.ctrl, e.count);
         else passCnt++;
      end
      bus.iInstReady = 1'b0;
      bus.iDataReady = 1'b0;
      @(negedge iClk);
      checkCnt++;
      if (bus.oState !== 4'd5 || bus.oMemWrite !== 1'b1 || bus.oRetire !== 1'b0)
         $display("[TB] FAIL sw_wait: got st=%0d memWrite=%b retire=%b, want st=5 memWrite=1 retire=0",
                  bus.oState, bus.oMemWrite, bus.oRetire);
      else passCnt++;
      #1 iRst_n = 1'b0;
      #1;
      checkCnt++;
      if (bus.oMemWrite !== 1'b0 || bus.oState !== 4'd0 || bus.oInstCount !== 4'd0 || bus.oInstRead !== 1'b0)
         $display("[TB] FAIL sw_midreset: got memWrite=%b st=%0d cnt=%0d instRead=%b, want 0 0 0 0",
                  bus.oMemWrite, bus.oState, bus.oInstCount, bus.oInstRead);
      else passCnt++;
      @(posedge iClk);
      #1 iRst_n = 1'b1;
      expCount = 4'd0;
   endtask

   task automatic test_fetch_wait_wrap();
      entry_t e, o;
      int irWrites = 0;
      applyStimulus(6'b000000, 6'b100001, 32'h0761_0000, 8'b0111_1000, 7);
      while (obsQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front();
         irWrites += int'(o.ctrl.irWrite);
         checkCnt++;
         if (o !== e) $display("[TB] FAIL fetchwait st%0d: got st=%0d ctrl=%h cnt=%0d, want st=%0d ctrl=%h cnt=%0d",
                               e.st, o.st, o.ctrl, o.count, e.st, e.ctrl, e.count);
         else passCnt++;
      end
      checkCnt++;
      if (irWrites != 1) $display("[TB] FAIL fetchwait_irwrite: got %0d pulses, want 1", irWrites);
      else passCnt++;
      for (int i = 0; i < 15; i++)
         applyStimulus((i % 2 == 0) ? 6'b000100 : 6'b000101, 6'd0, 32'h0000_0A10, 8'h07, 3);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front();
         checkCnt++;
         if (o !== e) $display("[TB] FAIL wrap st%0d: got st=%0d ctrl=%h cnt=%0d, want st=%0d ctrl=%h cnt=%0d",
                               e.st, o.st, o.ctrl, o.count, e.st, e.ctrl, e.count);
         else passCnt++;
      end
      checkCnt++;
      if (bus.oInstCount !== 4'd0) $display("[TB] FAIL wrap_count: got %0d, want 0", bus.oInstCount);
      else passCnt++;
   endtask

   task automatic test_illegal();
      entry_t e, o;
      int activity = 0;
      applyStimulus(6'b111111, 6'd0, 32'h0000_0D10, 8'h07, 3);
      for (int i = 0; i < 20; i++)
         applyStimulus(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 32'h0000_000D,
                       8'($urandom_range(0, 1)), 1);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front();
         if (o.st == 4'd13)
            activity += int'(o.ctrl.instRead) + int'(o.ctrl.memRead) + int'(o.ctrl.memWrite)
                      + int'(o.ctrl.retire) + int'(o.ctrl.pcWrite);
         checkCnt++;
         if (o !== e) $display("[TB] FAIL illegal st%0d: got st=%0d ctrl=%h cnt=%0d, want st=%0d ctrl=%h cnt=%0d",
                               e.st, o.st, o.ctrl, o.count, e.st, e.ctrl, e.count);
         else passCnt++;
      end
      checkCnt++;
      if (activity != 0) $display("[TB] FAIL illegal_activity: got %0d strobes, want 0", activity);
      else passCnt++;
   endtask

   initial begin
      test_reset();
      test_addu();
      test_lw_wait();
      test_branch();
      test_jumps();
      test_sw_reset();
      test_fetch_wait_wrap();
      test_illegal();
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule

// File: doc/multicyc_main_fsm.md
# multicyc_main_fsm

Main control state machine for the multicycle MIPS core. It sequences one shared ALU, the IR/PC registers, the register file and the instruction/data memory ports over 3–5 states per instruction, plus wait states. Memory ports use a request/ready handshake. It drives the same ALUOp encoding consumed by `multicyc_alu_ctrl`, and it counts retired instructions.

## Interface
- COUNT_W, 32, width of retired-instruction counter
- iClk  in  1  clock
- iRst_n  in  1  reset; asynchronous, active-low
- iOpCode  in  6  IR[31:26], valid from DECODE onward
- iFunct  in  6  IR[5:0]
- iInstReady  in  1  instruction memory has data this cycle
- iDataReady  in  1  data memory read data valid / write accepted this cycle
- oInstRead  out  1  instruction fetch request
- oIRWrite  out  1  load IR
- oPCWrite  out  1  unconditional PC load
- oBranch  out  1  conditional PC load: datapath loads PC when Zero==oBranchEq
- oBranchEq  out  1  1=beq, 0=bne
- oPCSrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs
- oAluSrcA  out  1  0 PC, 1 rs
- oAluSrcB  out  2  00 rt, 01 const 4, 10 ext imm, 11 sign-ext imm<<2
- oAluOp  out  2  00 add, 01 sub, 10 funct, 11 opcode (`multicyc_alu_ctrl` encoding)
- oMemRead  out  1  data read request
- oMemWrite  out  1  data write request
- oRegWrite  out  1  register file write
- oRegDst  out  2  00 rt, 01 rd, 10 $31
- oMemtoReg  out  2  write data: 00 ALUOut, 01 MDR, 10 PC (already PC+4)
- oRetire  out  1  one-cycle pulse on instruction completion
- oInstCount  out  COUNT_W  retired count
- oIllegal  out  1  sticky illegal-opcode flag
- oState  out  4  current state, debug

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, RWB=7, EXEC_I=8, IWB=9, BRANCH=10, JUMP=11, JREG=12, ILLEGAL=13.
- FETCH: oInstRead=1, AluSrcA=0, AluSrcB=01, AluOp=00. Stays while !iInstReady. On ready: oIRWrite=1, oPCWrite=1, PCSrc=00, then DECODE.
- DECODE: AluSrcA=0, AluSrcB=11, AluOp=00 (branch target into ALUOut). Dispatch:
  - LW/SW → MEMADR
  - RSTYLE with funct JR(001000)/JALR(001001) → JREG
  - other RSTYLE → EXEC_R
  - LUI/ADDI/ADDIU/ANDI/ORI/SLTI/SLTIU → EXEC_I
  - BEQ/BNE → BRANCH
  - J/JAL → JUMP
  - any other → ILLEGAL
- MEMADR: AluSrcA=1, AluSrcB=10, AluOp=00. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: oMemRead=1 until iDataReady, then MEMWB.
- MEMWB: RegWrite, RegDst=00, MemtoReg=01, retire.
- MEMWR: oMemWrite=1 until iDataReady, then retire.
- EXEC_R: AluSrcA=1, AluSrcB=00, AluOp=10. RWB: RegWrite, RegDst=01, MemtoReg=00, retire.
- EXEC_I: AluSrcA=1, AluSrcB=10, AluOp=11. IWB: RegWrite, RegDst=00, MemtoReg=00, retire.
- BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, oBranch=1, oBranchEq=(opcode==BEQ), PCSrc=01, retire.
- JUMP: PCWrite, PCSrc=10. JAL additionally drives RegWrite, RegDst=10, MemtoReg=10. Retire.
- JREG: PCWrite, PCSrc=11. JALR additionally drives RegWrite, RegDst=01, MemtoReg=10. Retire.
- Retire: oRetire=1 for the final cycle and oInstCount+1, which wraps to 0 after 2^COUNT_W−1. The next state is FETCH.
- ILLEGAL: absorbing. oIllegal=1, all strobes 0, leaves only on reset.
- Unlisted outputs are 0 in every state, including the don't-care selects.

## Timing
- Reset (async, immediate): state FETCH, oInstCount=0, oIllegal=0, all strobes and selects 0. oInstRead is asserted combinationally from FETCH once reset is released.
- Strobes are Moore-decoded from state. Exceptions, which are combinational on ready: oIRWrite and oPCWrite in FETCH, and the state advance out of FETCH/MEMRD/MEMWR.
- Cycle counts with zero wait states:
  - R/I/SW: 4
  - LW: 5
  - branch/J/JAL/JR/JALR: 3
  - each cycle with ready low adds 1
- Ready asserted in the first request cycle is legal (zero-wait). Ready outside FETCH/MEMRD/MEMWR is ignored.
- Request signals stay asserted, with stable selects, until the ready cycle inclusive.
- Reset mid-MEMWR/MEMRD drops the request within the same cycle (async). There is no partial retire.

## Structure
- Opcodes and functs come from `isa_define.v`.
- New `multicyc_define.v` holds the state codes and the `PCSRC_*`, `ALUSRCB_*`, `REGDST_*`, `WBSRC_*`, `ALUOP_*` constants.
- One sub-module, `multicyc_fsm_outdec`: combinational state+opcode+ready → control outputs. The state register, next-state logic and counter stay in the top.

## Test plan
- Reset, then ADDU (op 000000, funct 100001), zero-wait → states 0,1,6,7,0. RegWrite only in state 7 with RegDst=01. oRetire at cycle 4; oInstCount=1.
- LW with iDataReady low 2 cycles in MEMRD → oMemRead high 3 cycles, 7 cycles total. A single RegWrite with MemtoReg=01.
- BEQ then BNE → 3 cycles each; BRANCH has oBranch=1, PCSrc=01, AluOp=01, oBranchEq 1 then 0.
- JAL → JUMP: PCWrite, PCSrc=10, RegWrite, RegDst=10, MemtoReg=10. JALR (funct 001001) → JREG: PCSrc=11, RegDst=01. JR → no RegWrite.
- Opcode 111111 → ILLEGAL; oIllegal=1 held 20 cycles with no requests, no retire, no PC write. A separate SW run has iRst_n dropped mid-MEMWR → oMemWrite=0 immediately, state 0, count 0.
- COUNT_W=4, fetch ready delayed 3 cycles → exactly one oIRWrite pulse. After 16 retires oInstCount=0.
